// File: rtl/lsu_if.sv
// Load/store unit bus bundle.
// Groups the pipeline request channel, the writeback response channel and the
// word-addressed data memory port into one interface.
//   slave  : the load/store controller (accepts requests, drives the memory)
//   master : the pipeline plus memory environment around it
// Signals:
//   req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata
//   resp_valid/resp_ready/resp_rdata/resp_err
//   mem_addr/mem_wdata/mem_read/mem_write (to memory), mem_rdata (from memory)
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store initiator for the MEM stage.
// Takes one byte-addressed load/store request, drives the word-addressed data
// memory (combinational read data), and returns lane-aligned, extended load
// data. Sub-word stores are done as read-modify-write.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : lsu_if.slave (request, response and memory port signals)
// Parameter:
//   DEPTH : number of 32-bit words in the data memory (power of two)
// Build option:
//   LSU_BOUNDS_CHECK_EN : when defined, word index >= DEPTH is reported as an
//   error with no memory access; when undefined the index wraps modulo DEPTH.
module lsu_ctrl #(
  parameter int DEPTH = 1024
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        accept;
  logic        bad_align;
  logic        out_of_range;
  logic [31:0] word_idx;

  // Request fields held for the RD/WR/RESP states
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;

  logic        unused_addr_bits;

  assign bus.req_ready    = (state == IDLE);
  assign accept           = bus.req_valid && (state == IDLE);
  assign unused_addr_bits = ^bus.req_addr;

  always_comb begin
    bad_align = 1'b0;
    case (bus.req_size)
      2'b01:   bad_align = bus.req_addr[0];
      2'b10:   bad_align = |bus.req_addr[1:0];
      2'b11:   bad_align = 1'b1;
      default: bad_align = 1'b0;
    endcase
  end

`ifdef LSU_BOUNDS_CHECK_EN
  assign word_idx     = {2'b00, bus.req_addr[31:2]};
  assign out_of_range = (word_idx >= 32'(DEPTH));
`else
  // Upper index bits are dropped so the access wraps inside the memory
  assign word_idx     = 32'(bus.req_addr[AW+1:2]);
  assign out_of_range = 1'b0;
`endif

  // Lane select plus sign/zero extension, little-endian lanes
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace one lane of the old word with the new store data
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] size,
                                        input logic [1:0] off, input logic [15:0] wd);
    logic [31:0] r;
    r = w;
    case (size)
      2'b00: r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (off[1]) r[31:16] = wd;
        else        r[15:0]  = wd;
      end
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write  <= bus.req_write;
      lat_size   <= bus.req_size;
      lat_signed <= bus.req_signed;
      lat_off    <= bus.req_addr[1:0];
      lat_wdata  <= bus.req_wdata[15:0];
    end
  end

  // The read word is consumed at the end of RD straight into either the
  // merged store word (mem_wdata) or the extracted load result (resp_rdata),
  // so those registers serve as the word buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bad_align || out_of_range) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              bus.mem_addr <= word_idx;
              if (bus.req_write && (bus.req_size == 2'b10)) begin
                state         <= WR;
                bus.mem_write <= 1'b1;
                bus.mem_wdata <= bus.req_wdata;
              end else begin
                state        <= RD;
                bus.mem_read <= 1'b1;
              end
            end
          end
        end
        RD: begin
          bus.mem_read <= 1'b0;
          if (lat_write) begin
            state         <= WR;
            bus.mem_write <= 1'b1;
            bus.mem_wdata <= merge(bus.mem_rdata, lat_size, lat_off, lat_wdata);
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= extract(bus.mem_rdata, lat_size, lat_off, lat_signed);
          end
        end
        WR: begin
          bus.mem_write  <= 1'b0;
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
